// File: rtl/hgc_pkg.sv
// Shared definitions for the HGC mode/control front end: register offsets,
// control-register bit positions and the write-masking helper.
package hgc_pkg;

  localparam logic [3:0] OFS_CTRL     = 4'h8;
  localparam logic [3:0] OFS_LPEN_SET = 4'h9;
  localparam logic [3:0] OFS_STATUS   = 4'hA;
  localparam logic [3:0] OFS_LPEN_CLR = 4'hB;
  localparam logic [3:0] OFS_CFG      = 4'hF;

  localparam int unsigned BIT_GRPH_MODE = 1;
  localparam int unsigned BIT_VIDEO_EN  = 3;
  localparam int unsigned BIT_BLINK_EN  = 5;
  localparam int unsigned BIT_GRPH_PAGE = 7;

  localparam logic [7:0] CTRL_RESET_DEFAULT = 8'h28;

  // Graphics mode and page 1 are only reachable when the config switch allows them.
  function automatic logic [7:0] mask_ctrl(input logic [7:0] v, input logic [1:0] cfg);
    mask_ctrl = {v[7] & cfg[1], v[6:2], v[1] & cfg[0], v[0]};
  endfunction

endpackage

// File: rtl/hgc_sync_edge.sv
// Synchroniser with edge detection. Edges are suppressed until the synced
// level has been seen at its idle (reset) value after reset release.
module hgc_sync_edge #(
  parameter int unsigned STAGES    = 2,
  parameter logic        RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic lvl_vld;
  logic prev;
  logic armed;

  if (STAGES == 0) begin : g_direct
    assign level   = din;
    assign lvl_vld = 1'b1;
  end else begin : g_sync
    logic [STAGES-1:0] sreg;
    logic [STAGES-1:0] vreg;

    // vreg tracks which stages hold samples taken after reset release
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        sreg <= {STAGES{RESET_VAL}};
        vreg <= '0;
      end else begin
        sreg[0] <= din;
        vreg[0] <= 1'b1;
        for (int unsigned i = 1; i < STAGES; i++) begin
          sreg[i] <= sreg[i-1];
          vreg[i] <= vreg[i-1];
        end
      end
    end

    assign level   = sreg[STAGES-1];
    assign lvl_vld = vreg[STAGES-1];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev  <= RESET_VAL;
      armed <= 1'b0;
    end else begin
      prev  <= level;
      armed <= armed | (lvl_vld & (level == RESET_VAL));
    end
  end

  assign rise = armed & level & ~prev;
  assign fall = armed & ~level & prev;

endmodule

// File: rtl/hgc_mode_ctrl.sv
// HGC register/control front end: ISA I/O decode, mode control with optional
// vblank-deferred apply, light-pen latch, status/CRTC read mux, frame blink.
module hgc_mode_ctrl
  import hgc_pkg::*;
#(
  parameter logic [15:0] IO_BASE_ADDR = 16'h3B0,
  parameter int unsigned SYNC_STAGES  = 2,
  parameter int unsigned MODE_DEFER   = 1,
  parameter int unsigned BLINK_FRAMES = 16,
  parameter logic [7:0]  CTRL_RESET   = CTRL_RESET_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] bus_a,
  input  logic        bus_aen,
  input  logic        bus_ior_l,
  input  logic        bus_iow_l,
  input  logic [7:0]  bus_d,
  output logic [7:0]  bus_out,
  output logic        bus_dir,
  input  logic        hercules_hw,
  output logic        crtc_cs,
  input  logic [7:0]  crtc_dout,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        vblank_in,
  input  logic        video_in,
  input  logic [13:0] crtc_ma,
  input  logic        lpen_in,
  output logic [13:0] lpen_addr,
  output logic        lpen_flag,
  output logic [7:0]  ctrl_active,
  output logic        mode_pending,
  output logic        grph_mode,
  output logic        grph_page,
  output logic        video_enabled,
  output logic        blink_enabled,
  output logic        hsync,
  output logic        blink
);

  localparam int unsigned CW = (BLINK_FRAMES < 2) ? 1 : $clog2(BLINK_FRAMES + 1);
  localparam logic [CW-1:0] BLINK_LAST = CW'((BLINK_FRAMES == 0) ? 0 : BLINK_FRAMES - 1);

  logic iow_fall, lpen_rise, vsync_rise, vblank_rise;
  logic unused_ior_level, unused_ior_rise, unused_ior_fall;
  logic unused_iow_level, unused_iow_rise;
  logic unused_lpen_level, unused_lpen_fall;
  logic unused_vs_level, unused_vs_fall, unused_vb_level, unused_vb_fall;

  hgc_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_ior (
    .clk(clk), .reset(reset), .din(bus_ior_l),
    .level(unused_ior_level), .rise(unused_ior_rise), .fall(unused_ior_fall)
  );
  hgc_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_iow (
    .clk(clk), .reset(reset), .din(bus_iow_l),
    .level(unused_iow_level), .rise(unused_iow_rise), .fall(iow_fall)
  );
  hgc_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_lpen (
    .clk(clk), .reset(reset), .din(lpen_in),
    .level(unused_lpen_level), .rise(lpen_rise), .fall(unused_lpen_fall)
  );
  // vsync/vblank are already clk-synchronous: edge detect only
  hgc_sync_edge #(.STAGES(0), .RESET_VAL(1'b0)) u_vsync (
    .clk(clk), .reset(reset), .din(vsync_in),
    .level(unused_vs_level), .rise(vsync_rise), .fall(unused_vs_fall)
  );
  hgc_sync_edge #(.STAGES(0), .RESET_VAL(1'b0)) u_vblank (
    .clk(clk), .reset(reset), .din(vblank_in),
    .level(unused_vb_level), .rise(vblank_rise), .fall(unused_vb_fall)
  );

  logic       card_sel, io_block, status_cs;
  logic       wr_ctrl, wr_lpen_set, wr_lpen_clr, wr_cfg;
  logic [1:0] cfg;
  logic [7:0] pending;
  logic [7:0] ctrl_masked;
  logic [CW-1:0] blink_cnt;

  assign card_sel  = hercules_hw & ~bus_aen;
  assign io_block  = card_sel & (bus_a[15:4] == IO_BASE_ADDR[15:4]);
  assign crtc_cs   = card_sel & (bus_a[15:3] == IO_BASE_ADDR[15:3]);
  assign status_cs = io_block & (bus_a[3:0] == OFS_STATUS);

  assign wr_ctrl     = iow_fall & io_block & (bus_a[3:0] == OFS_CTRL);
  assign wr_lpen_set = iow_fall & io_block & (bus_a[3:0] == OFS_LPEN_SET);
  assign wr_lpen_clr = iow_fall & io_block & (bus_a[3:0] == OFS_LPEN_CLR);
  assign wr_cfg      = iow_fall & io_block & (bus_a[3:0] == OFS_CFG);
  assign ctrl_masked = mask_ctrl(bus_d, cfg);

  always_comb begin
    bus_out = '0;
    if (!bus_ior_l) begin
      if (status_cs)
        bus_out = {~vsync_in, 3'b111, video_in, 1'b0, lpen_flag, hsync_in};
      else if (crtc_cs && bus_a[0])
        bus_out = crtc_dout;
    end
  end
  assign bus_dir = (crtc_cs | status_cs) & ~bus_ior_l;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctrl_active  <= CTRL_RESET;
      pending      <= CTRL_RESET;
      mode_pending <= 1'b0;
      cfg          <= 2'b00;
      lpen_flag    <= 1'b0;
      lpen_addr    <= '0;
      blink        <= 1'b1;
      blink_cnt    <= '0;
    end else begin
      // A write coinciding with the vblank edge bypasses staging entirely.
      if (wr_ctrl) begin
        pending <= ctrl_masked;
        if (MODE_DEFER == 0 || vblank_rise) begin
          ctrl_active  <= ctrl_masked;
          mode_pending <= 1'b0;
        end else begin
          mode_pending <= 1'b1;
        end
      end else if (MODE_DEFER != 0 && vblank_rise && mode_pending) begin
        ctrl_active  <= pending;
        mode_pending <= 1'b0;
      end

      if (wr_cfg)
        cfg <= bus_d[1:0];

      if (wr_lpen_clr) begin
        lpen_flag <= 1'b0;
      end else if (wr_lpen_set || (lpen_rise && !lpen_flag)) begin
        lpen_flag <= 1'b1;
        lpen_addr <= crtc_ma;
      end

      if (vsync_rise && BLINK_FRAMES != 0) begin
        if (blink_cnt == BLINK_LAST) begin
          blink_cnt <= '0;
          blink     <= ~blink;
        end else begin
          blink_cnt <= blink_cnt + CW'(1);
        end
      end
    end
  end

  assign grph_mode     = ctrl_active[BIT_GRPH_MODE];
  assign grph_page     = ctrl_active[BIT_GRPH_PAGE];
  assign video_enabled = ctrl_active[BIT_VIDEO_EN];
  assign blink_enabled = ctrl_active[BIT_BLINK_EN];
  assign hsync         = hsync_in & video_enabled;

endmodule

// File: tb/tb_hgc_mode_ctrl.sv
// Bench for hgc_mode_ctrl: read-mux vector table, directed multi-cycle
// sequences, and random bus traffic against a transaction-level model.
module tb_hgc_mode_ctrl;

  localparam int unsigned SYNC = 2;
  localparam int unsigned BF   = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] bus_a = 16'h0000;
  logic        bus_aen = 1'b0, bus_ior_l = 1'b1, bus_iow_l = 1'b1;
  logic [7:0]  bus_d = 8'h00;
  logic [7:0]  bus_out;
  logic        bus_dir, crtc_cs;
  logic        hercules_hw = 1'b1;
  logic [7:0]  crtc_dout = 8'h00;
  logic        hsync_in = 1'b0, vsync_in = 1'b0, vblank_in = 1'b0, video_in = 1'b0;
  logic [13:0] crtc_ma = '0;
  logic        lpen_in = 1'b0;
  logic [13:0] lpen_addr;
  logic        lpen_flag, mode_pending;
  logic [7:0]  ctrl_active;
  logic        grph_mode, grph_page, video_enabled, blink_enabled, hsync, blink;

  hgc_mode_ctrl #(
    .IO_BASE_ADDR(16'h3B0), .SYNC_STAGES(SYNC), .MODE_DEFER(1),
    .BLINK_FRAMES(BF), .CTRL_RESET(8'h28)
  ) dut (
    .clk(clk), .reset(reset), .bus_a(bus_a), .bus_aen(bus_aen),
    .bus_ior_l(bus_ior_l), .bus_iow_l(bus_iow_l), .bus_d(bus_d),
    .bus_out(bus_out), .bus_dir(bus_dir), .hercules_hw(hercules_hw),
    .crtc_cs(crtc_cs), .crtc_dout(crtc_dout), .hsync_in(hsync_in),
    .vsync_in(vsync_in), .vblank_in(vblank_in), .video_in(video_in),
    .crtc_ma(crtc_ma), .lpen_in(lpen_in), .lpen_addr(lpen_addr),
    .lpen_flag(lpen_flag), .ctrl_active(ctrl_active), .mode_pending(mode_pending),
    .grph_mode(grph_mode), .grph_page(grph_page), .video_enabled(video_enabled),
    .blink_enabled(blink_enabled), .hsync(hsync), .blink(blink)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Transaction-level model state
  logic [7:0]  m_ctrl, m_pval;
  logic        m_pend, m_lflag;
  logic [1:0]  m_cfg;
  logic [13:0] m_laddr;
  int unsigned m_vs;

  typedef struct {
    logic [15:0] a;
    logic        ior_l, aen, hw;
    logic [7:0]  dout;
    logic        vs, vid, hs;
    logic        chk_out;
    logic [7:0]  eout;
    logic        edir, ecs;
  } vec_t;
  vec_t vecs[12];

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ctrl = 8'h28; m_pval = 8'h28; m_pend = 1'b0; m_cfg = 2'b00;
    m_lflag = 1'b0; m_laddr = '0; m_vs = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc(3);
    reset = 1'b0;
    model_reset();
    cyc(4);
  endtask

  function automatic logic [7:0] allowed(input logic [7:0] d, input logic [1:0] c);
    return d & {c[1], 5'b11111, c[0], 1'b1};
  endfunction

  function automatic logic exp_blink();
    return ((m_vs / BF) % 2) == 0;
  endfunction

  task automatic model_write(input logic [15:0] a, input logic [7:0] d,
                             input logic aen, input logic hw);
    if (hw && !aen && a[15:4] == 12'h03B) begin
      case (a[3:0])
        4'h8: begin m_pval = allowed(d, m_cfg); m_pend = 1'b1; end
        4'h9: begin m_lflag = 1'b1; m_laddr = crtc_ma; end
        4'hB: m_lflag = 1'b0;
        4'hF: m_cfg = d[1:0];
        default: ;
      endcase
    end
  endtask

  task automatic bus_write(input logic [15:0] a, input logic [7:0] d,
                           input logic aen, input logic hw);
    bus_a = a; bus_d = d; bus_aen = aen; hercules_hw = hw;
    cyc(1);
    bus_iow_l = 1'b0;
    cyc(SYNC + 3);
    bus_iow_l = 1'b1;
    cyc(3);
    model_write(a, d, aen, hw);
    bus_aen = 1'b0; hercules_hw = 1'b1;
  endtask

  task automatic pulse_vblank();
    vblank_in = 1'b1; cyc(2); vblank_in = 1'b0; cyc(2);
    if (m_pend) begin m_ctrl = m_pval; m_pend = 1'b0; end
  endtask

  task automatic pulse_vsync();
    vsync_in = 1'b1; cyc(2); vsync_in = 1'b0; cyc(2);
    m_vs++;
  endtask

  task automatic pulse_lpen(input logic [13:0] ma);
    crtc_ma = ma; cyc(1);
    lpen_in = 1'b1; cyc(SYNC + 3);
    lpen_in = 1'b0; cyc(SYNC + 2);
    if (!m_lflag) begin m_lflag = 1'b1; m_laddr = ma; end
  endtask

  task automatic check_state(input string tag);
    chk({tag, ".ctrl"},     {24'h0, ctrl_active}, {24'h0, m_ctrl});
    chk({tag, ".pending"},  {31'h0, mode_pending}, {31'h0, m_pend});
    chk({tag, ".lflag"},    {31'h0, lpen_flag},    {31'h0, m_lflag});
    chk({tag, ".laddr"},    {18'h0, lpen_addr},    {18'h0, m_laddr});
    chk({tag, ".blink"},    {31'h0, blink},        {31'h0, exp_blink()});
    chk({tag, ".grph"},     {30'h0, grph_page, grph_mode}, {30'h0, m_ctrl[7], m_ctrl[1]});
    chk({tag, ".vid_blen"}, {30'h0, video_enabled, blink_enabled}, {30'h0, m_ctrl[3], m_ctrl[5]});
  endtask

  task automatic read_chk(input logic [15:0] a, input logic [7:0] dout);
    logic [7:0] eo;
    logic       ed;
    bus_a = a; crtc_dout = dout; bus_ior_l = 1'b0;
    #1;
    eo = 8'h00; ed = 1'b0;
    if (a == 16'h3BA) begin
      eo = {~vsync_in, 3'b111, video_in, 1'b0, m_lflag, hsync_in};
      ed = 1'b1;
    end else if (a >= 16'h3B0 && a <= 16'h3B7) begin
      ed = 1'b1;
      if (a[0]) eo = dout;
    end
    chk("rnd.read_out", {24'h0, bus_out}, {24'h0, eo});
    chk("rnd.read_dir", {31'h0, bus_dir}, {31'h0, ed});
    bus_ior_l = 1'b1;
    cyc(1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{16'h3B5, 1'b0, 1'b0, 1'b1, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b1, 8'h5A, 1'b1, 1'b1};
    vecs[1]  = '{16'h3B4, 1'b0, 1'b0, 1'b1, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 1'b1};
    vecs[2]  = '{16'h3BA, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 8'hF9, 1'b1, 1'b0};
    vecs[3]  = '{16'h3BA, 1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 8'h70, 1'b1, 1'b0};
    vecs[4]  = '{16'h3BA, 1'b1, 1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0};
    vecs[5]  = '{16'h3B5, 1'b0, 1'b1, 1'b1, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0};
    vecs[6]  = '{16'h3B5, 1'b0, 1'b0, 1'b0, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0};
    vecs[7]  = '{16'h3B8, 1'b0, 1'b0, 1'b1, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0};
    vecs[8]  = '{16'h3D5, 1'b0, 1'b0, 1'b1, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0};
    vecs[9]  = '{16'h3B1, 1'b0, 1'b0, 1'b1, 8'hC3, 1'b0, 1'b0, 1'b0, 1'b1, 8'hC3, 1'b1, 1'b1};
    vecs[10] = '{16'h3B7, 1'b1, 1'b0, 1'b1, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1};
    vecs[11] = '{16'h3BA, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 8'hF1, 1'b1, 1'b0};

    model_reset();
    do_reset();
    chk("reset.ctrl",    {24'h0, ctrl_active}, 32'h28);
    chk("reset.pending", {31'h0, mode_pending}, 32'h0);
    chk("reset.lflag",   {31'h0, lpen_flag}, 32'h0);
    chk("reset.laddr",   {18'h0, lpen_addr}, 32'h0);
    chk("reset.blink",   {31'h0, blink}, 32'h1);
    chk("reset.bits",    {28'h0, grph_page, grph_mode, video_enabled, blink_enabled}, 32'h3);

    // Combinational read-mux vectors
    for (int i = 0; i < 12; i++) begin
      bus_a = vecs[i].a; bus_ior_l = vecs[i].ior_l; bus_aen = vecs[i].aen;
      hercules_hw = vecs[i].hw; crtc_dout = vecs[i].dout; vsync_in = vecs[i].vs;
      video_in = vecs[i].vid; hsync_in = vecs[i].hs;
      cyc(1);
      if (vecs[i].chk_out)
        chk($sformatf("vec%0d.out", i), {24'h0, bus_out}, {24'h0, vecs[i].eout});
      chk($sformatf("vec%0d.dir", i), {31'h0, bus_dir}, {31'h0, vecs[i].edir});
      chk($sformatf("vec%0d.cs", i), {31'h0, crtc_cs}, {31'h0, vecs[i].ecs});
      chk($sformatf("vec%0d.hsync", i), {31'h0, hsync}, {31'h0, vecs[i].hs});
    end
    bus_ior_l = 1'b1; bus_aen = 1'b0; hercules_hw = 1'b1;
    vsync_in = 1'b0; video_in = 1'b0; hsync_in = 1'b0;
    do_reset();

    // Deferred apply at vblank, with graphics enabled by config
    bus_write(16'h3BF, 8'h03, 1'b0, 1'b1);
    bus_write(16'h3B8, 8'h82, 1'b0, 1'b1);
    chk("defer.pending", {31'h0, mode_pending}, 32'h1);
    chk("defer.ctrl_held", {24'h0, ctrl_active}, 32'h28);
    pulse_vblank();
    chk("defer.ctrl_applied", {24'h0, ctrl_active}, 32'h82);
    chk("defer.grph", {30'h0, grph_page, grph_mode}, 32'h3);
    chk("defer.pending_clr", {31'h0, mode_pending}, 32'h0);

    // Config masking, and no re-mask when config later opens
    bus_write(16'h3BF, 8'h00, 1'b0, 1'b1);
    bus_write(16'h3B8, 8'h8A, 1'b0, 1'b1);
    pulse_vblank();
    chk("mask.ctrl", {24'h0, ctrl_active}, 32'h08);
    bus_write(16'h3BF, 8'h03, 1'b0, 1'b1);
    pulse_vblank();
    chk("mask.no_remask", {24'h0, ctrl_active}, 32'h08);

    // Long strobe: exactly one write (a repeat would re-stage after the vblank)
    bus_a = 16'h3B8; bus_d = 8'hA2; cyc(1);
    bus_iow_l = 1'b0; cyc(20);
    vblank_in = 1'b1; cyc(2); vblank_in = 1'b0; cyc(28);
    bus_iow_l = 1'b1; cyc(3);
    chk("long.ctrl", {24'h0, ctrl_active}, 32'hA2);
    chk("long.pending", {31'h0, mode_pending}, 32'h0);
    crtc_ma = 14'h0111; bus_a = 16'h3B9; cyc(1);
    bus_iow_l = 1'b0; cyc(10);
    crtc_ma = 14'h0222; cyc(40);
    bus_iow_l = 1'b1; cyc(3);
    chk("long.lpen_addr", {18'h0, lpen_addr}, 32'h111);
    chk("long.lpen_flag", {31'h0, lpen_flag}, 32'h1);
    m_ctrl = 8'hA2; m_pend = 1'b0; m_lflag = 1'b1; m_laddr = 14'h0111;
    bus_write(16'h3BB, 8'h00, 1'b0, 1'b1);
    chk("long.lpen_clr", {31'h0, lpen_flag}, 32'h0);

    // Gated writes
    bus_write(16'h3B8, 8'h55, 1'b1, 1'b1);
    chk("aen.pending", {31'h0, mode_pending}, 32'h0);
    bus_write(16'h3B8, 8'h55, 1'b0, 1'b0);
    chk("hw0.pending", {31'h0, mode_pending}, 32'h0);
    pulse_vblank();
    chk("gated.ctrl", {24'h0, ctrl_active}, 32'hA2);

    // Light pen latch and status
    video_in = 1'b1;
    pulse_lpen(14'h0123);
    chk("lpen.flag", {31'h0, lpen_flag}, 32'h1);
    chk("lpen.addr", {18'h0, lpen_addr}, 32'h123);
    bus_a = 16'h3BA; bus_ior_l = 1'b0; #1;
    chk("lpen.status", {24'h0, bus_out}, 32'hFA);
    bus_ior_l = 1'b1; cyc(1);
    pulse_lpen(14'h0200);
    chk("lpen.addr_held", {18'h0, lpen_addr}, 32'h123);
    bus_write(16'h3BB, 8'h00, 1'b0, 1'b1);
    chk("lpen.cleared", {31'h0, lpen_flag}, 32'h0);
    video_in = 1'b0;

    // Clear and trigger landing on the same cycle: clear wins
    crtc_ma = 14'h03AB; bus_a = 16'h3BB; cyc(1);
    lpen_in = 1'b1; bus_iow_l = 1'b0;
    cyc(SYNC + 3);
    bus_iow_l = 1'b1; cyc(3);
    chk("lpen.clr_wins", {31'h0, lpen_flag}, 32'h0);
    lpen_in = 1'b0; cyc(SYNC + 2);

    // Write on the same cycle as the vblank edge goes straight to ctrl_active
    bus_write(16'h3B8, 8'h02, 1'b0, 1'b1);
    chk("same.pending_before", {31'h0, mode_pending}, 32'h1);
    bus_a = 16'h3B8; bus_d = 8'h80; cyc(1);
    bus_iow_l = 1'b0; cyc(SYNC);
    vblank_in = 1'b1; cyc(1);
    chk("same.ctrl", {24'h0, ctrl_active}, 32'h80);
    chk("same.pending", {31'h0, mode_pending}, 32'h0);
    vblank_in = 1'b0; bus_iow_l = 1'b1; cyc(3);
    vblank_in = 1'b1; cyc(2); vblank_in = 1'b0; cyc(2);
    chk("same.ctrl_after", {24'h0, ctrl_active}, 32'h80);

    // Blink divider: toggles on vsync rises 4 and 8
    do_reset();
    for (int r = 1; r <= 8; r++) begin
      pulse_vsync();
      chk($sformatf("blink.rise%0d", r), {31'h0, blink}, (r >= 4 && r < 8) ? 32'h0 : 32'h1);
    end

    // Reset in the middle of a write, with the strobe held low through release
    bus_write(16'h3B8, 8'h82, 1'b0, 1'b1);
    chk("rstmid.pending_before", {31'h0, mode_pending}, 32'h1);
    bus_a = 16'h3B8; bus_d = 8'hFF; cyc(1);
    bus_iow_l = 1'b0; cyc(1);
    reset = 1'b1; cyc(3); reset = 1'b0; cyc(10);
    chk("rstmid.ctrl", {24'h0, ctrl_active}, 32'h28);
    chk("rstmid.pending", {31'h0, mode_pending}, 32'h0);
    bus_iow_l = 1'b1; cyc(5);
    chk("rstmid.no_write", {31'h0, mode_pending}, 32'h0);
    bus_write(16'h3B8, 8'h0A, 1'b0, 1'b1);
    chk("rstmid.rearmed", {31'h0, mode_pending}, 32'h1);

    // Random traffic against the model
    do_reset();
    for (int it = 0; it < 200; it++) begin
      int unsigned op;
      op = $urandom_range(0, 4);
      case (op)
        0: begin
          logic [15:0] a;
          logic aen, hw;
          case ($urandom_range(0, 5))
            0: a = 16'h3B8;
            1: a = 16'h3B9;
            2: a = 16'h3BB;
            3: a = 16'h3BF;
            4: a = 16'h3B0 | 16'($urandom_range(0, 15));
            default: a = 16'h3D8;
          endcase
          aen = ($urandom_range(0, 7) == 0);
          hw  = ($urandom_range(0, 7) != 0);
          crtc_ma = 14'($urandom);
          bus_write(a, 8'($urandom), aen, hw);
        end
        1: pulse_vblank();
        2: pulse_vsync();
        3: pulse_lpen(14'($urandom));
        default: begin
          video_in = 1'($urandom);
          hsync_in = 1'($urandom);
          read_chk(16'h3B0 | 16'($urandom_range(0, 15)), 8'($urandom));
        end
      endcase
      check_state($sformatf("rnd%0d", it));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hgc_mode_ctrl.md
Name: hgc_mode_ctrl

Overview:
Parametrised successor to the HGC register/control front end. It decodes ISA I/O at IO_BASE_ADDR and owns the mode control, configuration switch, status and light-pen registers. It also muxes CRTC read data and generates the frame-based blink. Versus the current HGC front end, it adds edge-qualified synchronised I/O strobes, deferred mode switching at vblank, a light-pen latch, and a programmable frame blink divider. It sits between the ISA bus and the CRTC, sequencer and pixel blocks.

Parameters:
IO_BASE_ADDR, 16'h3B0, I/O base; registers at +4/+5 (CRTC), +8, +9, +A, +B, +F.
SYNC_STAGES, 2, synchroniser depth for bus_ior_l/bus_iow_l and lpen_in (min 2).
MODE_DEFER, 1, 1 = control writes staged and applied at next vblank rising edge; 0 = applied immediately.
BLINK_FRAMES, 16, vsync rising edges per blink toggle; 0 = blink held at 1.
CTRL_RESET, 8'h28, reset value of active and pending control registers.

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high
bus_a  in  16  ISA address
bus_aen  in  1  DMA AEN; decode is blocked when high
bus_ior_l / bus_iow_l  in  1  I/O strobes, active-low
bus_d  in  8  write data
bus_out  out  8  read data
bus_dir  out  1  high while this block drives read data
hercules_hw  in  1  card enable; all decode is gated by it
crtc_cs  out  1  CRTC select (+0..+7 decoded by bus_a[15:3])
crtc_dout  in  8  CRTC read data
hsync_in, vsync_in, vblank_in, video_in  in  1  CRTC/pixel timing, active-high
crtc_ma  in  14  CRTC memory address
lpen_in  in  1  light-pen trigger (asynchronous)
lpen_addr  out  14  captured MA for CRTC R16/R17
lpen_flag  out  1  light-pen latched
ctrl_active  out  8  applied control register
mode_pending  out  1  staged write not yet applied
grph_mode, grph_page, video_enabled, blink_enabled  out  1  ctrl_active bits 1, 7, 3, 5
hsync  out  1  hsync_in & video_enabled
blink  out  1  blink phase

Behaviour:
- Reset values: ctrl_active = pending = CTRL_RESET; mode_pending = 0; config_sw = 2'b00; lpen_flag = 0; lpen_addr = 0; blink = 1; blink counter = 0; synchronisers filled with 1 (lpen chain 0).
- Strobes pass through SYNC_STAGES flops. A write event is a one-cycle pulse on the synchronised iow falling edge, so each bus cycle produces exactly one write. Write latency is SYNC_STAGES+1 clk from iow_l fall.
- Writes to +8: value v' = {v[7]&cfg[1], v[6:2], v[1]&cfg[0], v[0]}.
  - MODE_DEFER=0: ctrl_active <= v'.
  - MODE_DEFER=1: pending <= v' and mode_pending <= 1. On the synchronous vblank_in rising edge while mode_pending: ctrl_active <= pending, mode_pending <= 0.
  - A write in the same cycle as the vblank edge loads v' directly into ctrl_active and clears mode_pending.
  - A second write while pending overwrites pending.
- Writes to +F: cfg <= d[1:0]. This does not re-mask ctrl_active or pending.
- Light pen: a synchronised lpen_in rising edge while lpen_flag=0 sets lpen_flag and captures crtc_ma into lpen_addr. Further edges are ignored until cleared.
  - Write +B clears lpen_flag. Write +9 sets it and captures crtc_ma.
  - Clear and trigger in the same cycle: clear wins.
- Read mux (combinational from raw strobes):
  - +A returns status {~vsync_in, 3'b111, video_in, 1'b0, lpen_flag, hsync_in}.
  - Odd CRTC addresses return crtc_dout.
  - Everything else returns 8'h00.
  - bus_dir = (crtc_cs | status_cs) & ~bus_ior_l.
- Blink: the counter increments on each vsync_in rising edge. When it reaches BLINK_FRAMES-1 it wraps to 0 and blink toggles. Counter width is $clog2(BLINK_FRAMES+1).
- hercules_hw=0 or bus_aen=1: no decode, no writes, bus_dir=0.
- Reset mid-write: all state returns to reset values. A strobe still low after reset release is not treated as a new falling edge.

Decomposition:
- Shared package hgc_pkg holds register offsets (OFS_CTRL=8, OFS_LPEN_SET=9, OFS_STATUS=A, OFS_LPEN_CLR=B, OFS_CFG=F), control bit indices, and the default CTRL_RESET.
- One sub-module, hgc_sync_edge (parametrised depth and reset level, outputs synced level plus rise/fall pulses), instantiated for ior, iow, lpen, and for vsync/vblank edge detection.

Test Plan:
- MODE_DEFER=1, cfg=3: write 8'h82 to 3B8 → mode_pending=1, ctrl_active stays 8'h28; after vblank_in rise → ctrl_active=8'h82, grph_mode=1, grph_page=1, mode_pending=0.
- cfg=0: write 8'h8A → applied value 8'h08; then cfg=2'b11 with no rewrite → ctrl_active still 8'h08.
- iow_l held low 50 clk on 3B8 → exactly one write. Same write with bus_aen=1 or hercules_hw=0 → no change, bus_dir=0.
- lpen_in pulse with crtc_ma=14'h0123 → lpen_flag=1, lpen_addr=0123, status read=8'hF? with bit1=1. Second pulse at MA=0200 → lpen_addr unchanged. Write 3BB → flag 0.
- BLINK_FRAMES=4: 8 vsync rises → blink toggles at rises 4 and 8 (1→0→1).
- Read 3B5 with crtc_dout=8'h5A → bus_out=5A, bus_dir=1. Read 3B4 → 00. Assert reset mid-pending → ctrl_active=8'h28, mode_pending=0.
